aux_uart_tx: RTL and testbench
==============================

Name: aux_uart_tx

Overview:
- Byte-oriented UART transmitter, 8N1 with optional second stop bit, fronted by a small FIFO.
- Drives the auxiliary UART TX pin on the board GPIO header. It is the return path of the aux UART boot/receive link, carrying boot acknowledgements and MCU debug output.
- Sits beside the MCU in the board top and runs on the undivided board clock.

Parameters:
- CLK_FREQUENCY, 50000000, input clock frequency in Hz.
- BAUD_RATE, 115200, serial bit rate in baud.
- FIFO_DEPTH, 16, byte FIFO entries; must be a power of two, at least 2.
- STOP_BITS, 1, number of stop bits; legal values are 1 or 2.

Ports:
- clk  input  1  board clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- wr_valid  input  1  producer offers wr_data this cycle.
- wr_data  input  8  byte to transmit.
- wr_ready  output  1  FIFO can accept a byte; equals not full.
- tx  output  1  serial line; idle high, registered.
- busy  output  1  a frame is on the line, or the FIFO is non-empty.
- level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset is asynchronous and active-high, and is applied immediately on assertion:
  - tx=1, busy=0, level=0, wr_ready=1;
  - FSM goes to IDLE, FIFO pointers are cleared, the baud counter and bit index are cleared.
- Reset mid-frame aborts the frame: tx returns high at once and no partial frame resumes.
- Divisor: DIV = (CLK_FREQUENCY + BAUD_RATE/2) / BAUD_RATE, an integer constant (434 at defaults).
  - Every bit (start, data, stop) holds tx for exactly DIV clk cycles.
  - Elaboration fails if DIV < 2, or if STOP_BITS or FIFO_DEPTH is illegal.
- FIFO write handshake:
  - A byte is written when wr_valid && wr_ready at a rising edge.
  - wr_valid while full is ignored; no overflow corruption, no sticky flag.
  - wr_data must be held only during the handshake cycle.
- FIFO is first-in first-out. On a same-cycle write and pop, level is unchanged.
- There is no bypass: a byte written into an empty FIFO is popped no earlier than the following edge.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If the FIFO is non-empty at an edge: pop the head into the shift register, tx<=0, baud counter<=0, go to START.
  - START: on the last cycle of the bit (counter == DIV-1): tx<=shift[0], bit index<=0, go to DATA.
  - DATA: LSB first. At each bit end, shift right and advance the index. After bit index 7 completes: tx<=1, go to STOP.
  - STOP: lasts STOP_BITS*DIV cycles. At its end:
    - if the FIFO is non-empty, pop, tx<=0 and go to START, so back-to-back frames have no idle gap;
    - otherwise go to IDLE.
- Latency: a byte written into an empty FIFO while IDLE at edge N drives tx low from edge N+1.
- Frame length: (9+STOP_BITS)*DIV cycles.
- busy = (state != IDLE) || (level != 0). It deasserts on the edge the final stop bit ends with an empty FIFO.
- The baud counter runs only outside IDLE and has width $clog2(STOP_BITS*DIV).

Decomposition:
- Package aux_uart_pkg:
  - enum typedef for the FSM states;
  - function computing DIV from CLK_FREQUENCY and BAUD_RATE;
  - constant for the 8-bit data width.
- One sub-module, aux_uart_tx_fifo: synchronous FIFO with parameter DEPTH and ports clk, reset, push, push_data, pop, pop_data, full, empty, level.
  - Pointers are one bit wider than the address.
  - pop_data is the combinational head.
- The top-level FSM, counter and shift register live in aux_uart_tx.

Test Plan:
All scenarios use CLK_FREQUENCY=1000, BAUD_RATE=100 (DIV=10), FIFO_DEPTH=4.
- Single byte: write 8'hA5 at edge N.
  - tx low from N+1 for 10 cycles.
  - Then bits 1,0,1,0,0,1,0,1 at 10 cycles each, then high for 10 cycles.
  - busy falls at N+101; level returns to 0.
- Back-to-back: write 8'h00 then 8'hFF on consecutive cycles. The second start bit begins exactly 100 cycles after the first, with no extra idle cycle.
- FIFO full: while frame 1 is active, write 5 more bytes with wr_valid held.
  - wr_ready drops once level=4 and the 5th write is ignored.
  - Exactly 5 frames go out in order.
- STOP_BITS=2: write 8'h3C. The stop period is 20 cycles, and the frame is 110 cycles long.
- Reset mid-frame: assert reset during DATA bit 3.
  - tx=1 and level=0 immediately.
  - After release with no writes, tx stays high and busy=0.
- Simultaneous push/pop: with level=1, write a byte on the stop-end cycle that pops. Level stays 1 and the byte order is preserved.

Source files
------------

// File: rtl/aux_uart_pkg.sv
// Shared definitions for the auxiliary UART transmitter.
//   tx_state_t  : transmitter FSM states
//   DATA_WIDTH  : byte width carried by the FIFO and the shift register
//   calc_div()  : clock cycles per serial bit, rounded to nearest
package aux_uart_pkg;

   localparam int DATA_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_t;

   function automatic int calc_div(input int clk_frequency, input int baud_rate);
      return (clk_frequency + baud_rate / 2) / baud_rate;
   endfunction

endpackage

// File: rtl/aux_uart_tx_fifo.sv
// Synchronous byte FIFO feeding the UART transmitter.
//   clk, reset : clock, asynchronous active-high reset
//   push       : write push_data (ignored while full)
//   pop        : drop the head entry (ignored while empty)
//   pop_data   : combinational head of the FIFO
//   full/empty : occupancy flags
//   level      : number of stored entries (0..DEPTH)
module aux_uart_tx_fifo
   import aux_uart_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    push,
   input  logic [DATA_WIDTH-1:0]   push_data,
   input  logic                    pop,
   output logic [DATA_WIDTH-1:0]   pop_data,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  level
);

   localparam int AW = $clog2(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("aux_uart_tx_fifo: DEPTH must be a power of two and at least 2");
   end

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW:0]           wr_ptr;
   logic [AW:0]           rd_ptr;
   logic                  do_push;
   logic                  do_pop;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign level    = wr_ptr - rd_ptr;
   assign pop_data = mem[rd_ptr[AW-1:0]];
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/aux_uart_tx.sv
// Auxiliary UART transmitter: 8 data bits, no parity, 1 or 2 stop bits,
// fronted by a byte FIFO. Frames are sent back to back while data is queued.
//   clk      : board clock
//   reset    : asynchronous active-high reset, aborts any frame in flight
//   wr_valid : producer offers wr_data
//   wr_data  : byte to transmit
//   wr_ready : FIFO not full
//   tx       : registered serial line, idle high
//   busy     : frame on the line or bytes queued
//   level    : FIFO occupancy
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit (low) for one bit period
// DATA  | eight data bits, LSB first
// STOP  | stop period of STOP_BITS bit periods, may chain into the next START
module aux_uart_tx
   import aux_uart_pkg::*;
#(
   parameter int CLK_FREQUENCY = 50000000,
   parameter int BAUD_RATE     = 115200,
   parameter int FIFO_DEPTH    = 16,
   parameter int STOP_BITS     = 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         wr_valid,
   input  logic [7:0]                   wr_data,
   output logic                         wr_ready,
   output logic                         tx,
   output logic                         busy,
   output logic [$clog2(FIFO_DEPTH):0]  level
);

   localparam int DIV         = calc_div(CLK_FREQUENCY, BAUD_RATE);
   localparam int STOP_CYCLES = STOP_BITS * DIV;
   localparam int CW          = $clog2(STOP_CYCLES);
   localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
   localparam logic [CW-1:0] STOP_LAST = CW'(STOP_CYCLES - 1);

   if (DIV < 2) begin : g_bad_div
      $error("aux_uart_tx: baud divisor must be at least 2");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("aux_uart_tx: STOP_BITS must be 1 or 2");
   end

   tx_state_t             state;
   tx_state_t             state_nxt;
   logic [CW-1:0]         cnt;
   logic [2:0]            bit_idx;
   logic [DATA_WIDTH-1:0] shift;
   logic                  tx_q;
   logic                  bit_end;
   logic                  stop_end;
   logic                  push;
   logic                  pop;
   logic [DATA_WIDTH-1:0] pop_data;
   logic                  full;
   logic                  empty;

   aux_uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (wr_data),
      .pop       (pop),
      .pop_data  (pop_data),
      .full      (full),
      .empty     (empty),
      .level     (level)
   );

   assign wr_ready = !full;
   assign push     = wr_valid && !full;
   assign tx       = tx_q;
   assign bit_end  = (cnt == BIT_LAST);
   assign stop_end = (cnt == STOP_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (!empty) state_nxt = ST_START;
         ST_START: if (bit_end) state_nxt = ST_DATA;
         ST_DATA:  if (bit_end && bit_idx == 3'd7) state_nxt = ST_STOP;
         ST_STOP:  if (stop_end) state_nxt = empty ? ST_IDLE : ST_START;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // The pop at the end of STOP is what removes the idle gap between frames.
   always_comb begin
      pop = 1'b0;
      case (state)
         ST_IDLE: pop = !empty;
         ST_STOP: pop = stop_end && !empty;
         default: pop = 1'b0;
      endcase
      busy = (state != ST_IDLE) || (level != '0);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt     <= '0;
         bit_idx <= '0;
         shift   <= '0;
         tx_q    <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               cnt  <= '0;
               tx_q <= 1'b1;
               if (pop) begin
                  shift <= pop_data;
                  tx_q  <= 1'b0;
               end
            end
            ST_START: begin
               if (bit_end) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  tx_q    <= shift[0];
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_DATA: begin
               if (bit_end) begin
                  cnt     <= '0;
                  bit_idx <= bit_idx + 3'd1;
                  shift   <= shift >> 1;
                  // shift[1] is the next data bit once this shift lands.
                  tx_q    <= (bit_idx == 3'd7) ? 1'b1 : shift[1];
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_STOP: begin
               if (stop_end) begin
                  cnt <= '0;
                  if (pop) begin
                     shift <= pop_data;
                     tx_q  <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               cnt  <= '0;
               tx_q <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aux_uart_tx.sv
// Bench for aux_uart_tx: two instances (1 and 2 stop bits) at DIV=10, FIFO depth 4.
// Bytes offered are queued as expectations; line monitors decode frames from tx
// with per-cycle timing checks and compare against the queues.
module tb_aux_uart_tx;

   localparam int CLK_F = 1000;
   localparam int BAUD  = 100;
   localparam int DEPTH = 4;
   localparam int DIV   = 10;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       wr_valid1 = 1'b0;
   logic       wr_valid2 = 1'b0;
   logic [7:0] wr_data1 = 8'h00;
   logic [7:0] wr_data2 = 8'h00;
   logic       wr_ready1, tx1, busy1;
   logic       wr_ready2, tx2, busy2;
   logic [2:0] level1, level2;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   logic [7:0] exp1[$];
   logic [7:0] exp2[$];
   int         st1[$];
   int         st2[$];

   aux_uart_tx #(
      .CLK_FREQUENCY (CLK_F),
      .BAUD_RATE     (BAUD),
      .FIFO_DEPTH    (DEPTH),
      .STOP_BITS     (1)
   ) dut1 (
      .clk      (clk),
      .reset    (reset),
      .wr_valid (wr_valid1),
      .wr_data  (wr_data1),
      .wr_ready (wr_ready1),
      .tx       (tx1),
      .busy     (busy1),
      .level    (level1)
   );

   aux_uart_tx #(
      .CLK_FREQUENCY (CLK_F),
      .BAUD_RATE     (BAUD),
      .FIFO_DEPTH    (DEPTH),
      .STOP_BITS     (2)
   ) dut2 (
      .clk      (clk),
      .reset    (reset),
      .wr_valid (wr_valid2),
      .wr_data  (wr_data2),
      .wr_ready (wr_ready2),
      .tx       (tx2),
      .busy     (busy2),
      .level    (level2)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic line_of(input int w);
      return (w == 0) ? tx1 : tx2;
   endfunction

   function automatic logic ready_of(input int w);
      return (w == 0) ? wr_ready1 : wr_ready2;
   endfunction

   function automatic logic busy_of(input int w);
      return (w == 0) ? busy1 : busy2;
   endfunction

   // Frame decoder: called at the first negedge the line is seen low.
   task automatic mon_frame(input int w);
      logic [7:0] b;
      logic [7:0] e;
      bit         bad;
      int         stop_cyc;
      b = 8'h00;
      bad = 1'b0;
      stop_cyc = (w == 0) ? DIV : 2 * DIV;
      if (w == 0) st1.push_back(cyc); else st2.push_back(cyc);
      for (int c = 1; c < DIV; c++) begin
         @(negedge clk);
         if (reset) return;
         if (line_of(w) !== 1'b0) bad = 1'b1;
      end
      for (int i = 0; i < 8; i++) begin
         for (int c = 0; c < DIV; c++) begin
            @(negedge clk);
            if (reset) return;
            if (c == 0) b[i] = line_of(w);
            else if (line_of(w) !== b[i]) bad = 1'b1;
         end
      end
      for (int c = 0; c < stop_cyc; c++) begin
         @(negedge clk);
         if (reset) return;
         if (line_of(w) !== 1'b1) bad = 1'b1;
      end
      chk((w == 0) ? "frame_timing_1" : "frame_timing_2", longint'(bad), 0);
      if (w == 0) begin
         if (exp1.size() == 0) chk("unexpected_frame_1", longint'(b), -1);
         else begin e = exp1.pop_front(); chk("frame_byte_1", longint'(b), longint'(e)); end
      end else begin
         if (exp2.size() == 0) chk("unexpected_frame_2", longint'(b), -1);
         else begin e = exp2.pop_front(); chk("frame_byte_2", longint'(b), longint'(e)); end
      end
   endtask

   initial forever begin
      @(negedge clk);
      if (!reset && tx1 === 1'b0) mon_frame(0);
   end

   initial forever begin
      @(negedge clk);
      if (!reset && tx2 === 1'b0) mon_frame(1);
   end

   // Drives one handshake cycle; returns #1 after the write edge.
   task automatic push(input int w, input logic [7:0] d);
      if (w == 0) begin
         wr_valid1 = 1'b1; wr_data1 = d; exp1.push_back(d);
      end else begin
         wr_valid2 = 1'b1; wr_data2 = d; exp2.push_back(d);
      end
      @(posedge clk); #1;
      if (w == 0) wr_valid1 = 1'b0; else wr_valid2 = 1'b0;
   endtask

   task automatic wait_idle(input int w, input int limit, output int fall_edge);
      int n;
      n = 0;
      while (busy_of(w) && n < limit) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= limit) chk("idle_timeout", 0, 1);
      fall_edge = cyc;
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic rnd(input int w, input int count);
      int gap;
      int t;
      for (int i = 0; i < count; i++) begin
         gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 200)) : 0;
         t = 0;
         repeat (gap) begin @(posedge clk); #1; end
         while (ready_of(w) !== 1'b1 && t < 3000) begin
            @(posedge clk); #1;
            t++;
         end
         if (t >= 3000) begin
            chk("rnd_ready_timeout", 0, 1);
            return;
         end
         push(w, 8'($urandom));
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int fe;
      bit bad;
      logic [7:0] full_bytes [5];
      full_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tx", tx1, 1);
      chk("rst_busy", busy1, 0);
      chk("rst_level", level1, 0);
      chk("rst_wr_ready", wr_ready1, 1);
      reset = 1'b0;
      @(posedge clk); #1;

      // Single byte
      st1.delete();
      push(0, 8'hA5);
      n = cyc;
      chk("t1_level_after_write", level1, 1);
      chk("t1_no_bypass_tx", tx1, 1);
      chk("t1_busy", busy1, 1);
      @(posedge clk); #1;
      chk("t1_tx_low", tx1, 0);
      chk("t1_level_popped", level1, 0);
      wait_idle(0, 400, fe);
      chk("t1_busy_fall", fe - n, 101);
      chk("t1_level_end", level1, 0);
      chk("t1_frames", st1.size(), 1);
      if (st1.size() > 0) chk("t1_start_latency", st1[0] - n, 1);

      // Back-to-back
      st1.delete();
      push(0, 8'h00);
      push(0, 8'hFF);
      wait_idle(0, 400, fe);
      chk("t2_frames", st1.size(), 2);
      if (st1.size() == 2) chk("t2_start_gap", st1[1] - st1[0], 100);

      // FIFO full
      st1.delete();
      push(0, 8'h5A);
      for (int k = 0; k < 5; k++) begin
         chk("t3_wr_ready", wr_ready1, (k < 4) ? 1 : 0);
         wr_valid1 = 1'b1;
         wr_data1 = full_bytes[k];
         if (k < 4) exp1.push_back(full_bytes[k]);
         @(posedge clk); #1;
      end
      wr_valid1 = 1'b0;
      chk("t3_level_full", level1, 4);
      chk("t3_wr_ready_full", wr_ready1, 0);
      wait_idle(0, 800, fe);
      chk("t3_frames", st1.size(), 5);
      chk("t3_exp_drained", exp1.size(), 0);

      // Two stop bits
      st2.delete();
      push(1, 8'h3C);
      n = cyc;
      wait_idle(1, 400, fe);
      chk("t4_busy_fall", fe - n, 111);
      chk("t4_frames", st2.size(), 1);
      if (st2.size() > 0) chk("t4_start_latency", st2[0] - n, 1);
      chk("t4_exp_drained", exp2.size(), 0);

      // Reset mid-frame, during data bit 3
      push(0, 8'hC3);
      n = cyc;
      push(0, 8'h22);
      push(0, 8'h33);
      wait_until(n + 45);
      chk("t5_level_before", level1, 2);
      #1 reset = 1'b1;
      #1;
      chk("t5_tx_high", tx1, 1);
      chk("t5_level_zero", level1, 0);
      chk("t5_busy", busy1, 0);
      chk("t5_wr_ready", wr_ready1, 1);
      exp1.delete();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      bad = 1'b0;
      repeat (150) begin
         @(posedge clk); #1;
         if (tx1 !== 1'b1 || busy1 !== 1'b0) bad = 1'b1;
      end
      chk("t5_quiet_after_reset", longint'(bad), 0);

      // Simultaneous push and pop at the stop-end edge
      st1.delete();
      push(0, 8'hA1);
      n = cyc;
      push(0, 8'hB2);
      chk("t6_level_idle_pop", level1, 1);
      wait_until(n + 100);
      push(0, 8'hC3);
      chk("t6_level_stop_pop", level1, 1);
      chk("t6_tx_start", tx1, 0);
      wait_idle(0, 500, fe);
      chk("t6_frames", st1.size(), 3);
      chk("t6_exp_drained", exp1.size(), 0);

      // Randomized traffic on both instances
      fork
         rnd(0, 25);
         rnd(1, 8);
      join
      wait_idle(0, 1000, fe);
      wait_idle(1, 1000, fe);
      repeat (3) @(posedge clk);
      chk("rnd_exp1_drained", exp1.size(), 0);
      chk("rnd_exp2_drained", exp2.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
